// File: rtl/multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier.
//   WIDTH_DEFAULT : default operand width (product is twice this)
//   state_t       : controller states
package multiplier_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multiplier_if.sv
// Operand/result bundle of the multiplier.
//   A, B  : multiplicand / multiplier, unsigned, WIDTH bits (driven by master)
//   prod  : product, 2*WIDTH bits (driven by slave, valid while ready=1)
//   ready : final result present (driven by slave)
interface multiplier_if
  import multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
);

  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2*WIDTH-1:0] prod;
  logic               ready;

  modport master (output A, B, input prod, ready);
  modport slave  (input A, B, output prod, ready);

endinterface

// File: rtl/multiplier_datapath.sv
// Datapath of the shift-and-add multiplier: mcand/mplier/acc registers, adder, shifters.
//   clk, reset  : clock, synchronous active-high clear
//   load        : capture a (zero-extended), b, and clear acc
//   step        : one shift-and-add iteration
//   a, b        : operands
//   acc_next    : acc after the current iteration (combinational)
//   mplier_zero : no set multiplier bits remain after the current shift
module multiplier_datapath
  import multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               mplier_zero
);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;

  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  // Looks at the shifted value so the controller can finish on this same edge.
  assign mplier_zero = (mplier >> 1) == '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/multiplier.sv
// Sequential unsigned shift-and-add multiplier with early termination.
// A reset pulse starts a multiplication: operands are captured on the first edge
// after release, and the result is held with ready=1 until the next reset.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset / restart
//   bus   : slave side of multiplier_if (A, B in; prod, ready out)
module multiplier
  import multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input logic         clk,
  input logic         reset,
  multiplier_if.slave bus
);

  state_t             state;
  logic [2*WIDTH-1:0] prod_q;
  logic               ready_q;
  logic               load;
  logic               step;
  logic [2*WIDTH-1:0] acc_next;
  logic               mplier_zero;

  assign load = (state == LOAD) && !reset;
  assign step = (state == CALC) && !reset;

  multiplier_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .step        (step),
    .a           (bus.A),
    .b           (bus.B),
    .acc_next    (acc_next),
    .mplier_zero (mplier_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= LOAD;
      prod_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.B == '0) begin
            prod_q  <= '0;
            ready_q <= 1'b1;
            state   <= DONE;
          end else begin
            state   <= CALC;
          end
        end
        CALC: begin
          if (mplier_zero) begin
            prod_q  <= acc_next;
            ready_q <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state   <= LOAD;
          prod_q  <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.prod  = prod_q;
  assign bus.ready = ready_q;

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: directed vectors with literal expectations,
// a per-cycle comparison against a behavioural product/latency model, and a random sweep.
module tb_multiplier;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  multiplier_if #(.WIDTH(8)) mif ();

  multiplier #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Edges from reset release to ready: operands captured on edge 1, then one edge per
  // multiplier bit up to and including the highest set bit.
  function automatic int lat_of(input logic [7:0] b);
    int l = 1;
    for (int i = 0; i < 8; i++) if (b[i]) l = i + 2;
    return l;
  endfunction

  // Behavioural model: operands seen at the first non-reset edge, edge count since then.
  logic       m_armed = 1'b0;
  logic       m_loaded = 1'b0;
  int         m_cyc = 0;
  logic [7:0] m_a, m_b;

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      m_armed  = 1'b1;
      m_loaded = 1'b0;
      m_cyc    = 0;
    end else if (m_armed) begin
      if (!m_loaded) begin
        m_a      = mif.A;
        m_b      = mif.B;
        m_loaded = 1'b1;
        m_cyc    = 1;
      end else if (m_cyc < 100000) begin
        m_cyc++;
      end
    end
  end

  always @(negedge clk) begin
    logic        e_ready;
    logic [15:0] e_prod;
    if (m_armed) begin
      e_ready = m_loaded && (m_cyc >= lat_of(m_b));
      e_prod  = e_ready ? 16'(m_a) * 16'(m_b) : 16'h0;
      chk("model ready", {31'b0, mif.ready}, {31'b0, e_ready});
      chk("model prod", {16'b0, mif.prod}, {16'b0, e_prod});
    end
  end

  // One reset pulse, then count edges to ready. chg_at>0 rewrites A after that many edges.
  task automatic run(input logic [7:0] a, input logic [7:0] b, input int exp_lat,
                     input logic [15:0] exp_p, input string nm, input int chg_at);
    int   n = 0;
    logic got = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mif.A = a;
    mif.B = b;
    @(negedge clk);
    reset = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (chg_at > 0 && n == chg_at) mif.A = 8'h01;
      if (mif.ready === 1'b1) got = 1'b1;
    end
    chk({nm, " latency"}, n, exp_lat);
    chk({nm, " prod"}, {16'b0, mif.prod}, {16'b0, exp_p});
  endtask

  initial begin
    reset = 1'b1;
    mif.A = 8'h00;
    mif.B = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", {31'b0, mif.ready}, 32'd0);
    chk("reset prod", {16'b0, mif.prod}, 32'd0);

    run(8'h0F, 8'h09, 5, 16'h0087, "0f*09", 0);
    #300;
    chk("0f*09 hold ready", {31'b0, mif.ready}, 32'd1);
    chk("0f*09 hold prod", {16'b0, mif.prod}, 32'h0087);

    // Two-cycle reset while in DONE.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst2 ready c1", {31'b0, mif.ready}, 32'd0);
    chk("rst2 prod c1", {16'b0, mif.prod}, 32'd0);
    @(posedge clk); #1;
    chk("rst2 ready c2", {31'b0, mif.ready}, 32'd0);
    chk("rst2 prod c2", {16'b0, mif.prod}, 32'd0);
    run(8'h0F, 8'h09, 5, 16'h0087, "0f*09 again", 0);

    run(8'hFF, 8'hFF, 9, 16'hFE01, "ff*ff", 0);
    run(8'h00, 8'h80, 9, 16'h0000, "00*80", 0);
    run(8'hAB, 8'h00, 1, 16'h0000, "ab*00", 0);

    // A rewritten mid-CALC, then again in DONE.
    run(8'h0F, 8'h09, 5, 16'h0087, "a change calc", 2);
    @(negedge clk);
    mif.A = 8'h01;
    mif.B = 8'h00;
    repeat (4) @(negedge clk);
    chk("a change done prod", {16'b0, mif.prod}, 32'h0087);
    chk("a change done ready", {31'b0, mif.ready}, 32'd1);

    // Reset mid-CALC aborts; new operands then multiply correctly.
    @(negedge clk);
    reset = 1'b1;
    mif.A = 8'hFF;
    mif.B = 8'hFF;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort ready", {31'b0, mif.ready}, 32'd0);
    chk("abort prod", {16'b0, mif.prod}, 32'd0);
    run(8'h12, 8'h34, 7, 16'h03A8, "12*34", 0);

    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run(ra, rb, lat_of(rb), 16'(ra) * 16'(rb), "sweep", 0);
      repeat (2) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
